// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point datapath.
// Field helpers accept operands zero-extended to 64 bits; formats up to 64 bits are supported.
package fp_pkg;

  typedef enum logic [2:0] {FpZero, FpNorm, FpInf, FpQnan, FpSnan} fp_class_e;

  typedef enum logic {RoundRne = 1'b0, RoundRtz = 1'b1} round_mode_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  function automatic logic [63:0] fp_exp_field(logic [63:0] v, int unsigned eb, int unsigned mb);
    return (v >> mb) & ((64'd1 << eb) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_mant_field(logic [63:0] v, int unsigned mb);
    return v & ((64'd1 << mb) - 64'd1);
  endfunction

  // Subnormals classify as zero: the datapath flushes them on input.
  function automatic fp_class_e fp_classify(logic [63:0] v, int unsigned eb, int unsigned mb);
    logic [63:0] e;
    logic [63:0] m;
    e = fp_exp_field(v, eb, mb);
    m = fp_mant_field(v, mb);
    if (e == 64'd0) return FpZero;
    if (e == ((64'd1 << eb) - 64'd1)) begin
      if (m == 64'd0) return FpInf;
      return m[mb-1] ? FpQnan : FpSnan;
    end
    return FpNorm;
  endfunction

  function automatic logic [63:0] fp_qnan(int unsigned eb, int unsigned mb);
    return (((64'd1 << eb) - 64'd1) << mb) | (64'd1 << (mb - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; zero_o flags an all-zero input vector.
module fp_lzc #(
  parameter  int unsigned Width = 27,
  localparam int unsigned CntW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic [CntW-1:0]  count_o,
  output logic             zero_o
);

  // Scanning upward leaves the position of the highest set bit as the last assignment.
  always_comb begin
    count_o = '0;
    zero_o  = 1'b1;
    for (int unsigned i = 0; i < Width; i++) begin
      if (vec_i[i]) begin
        count_o = CntW'(Width - 1 - i);
        zero_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Pipelined IEEE-754 adder/subtractor: operand capture, then align, add and normalise/round
// stages, with a valid/ready handshake and a global stall; subnormals are flushed to zero.
module fp_add_sub_pipe
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_BITS  = 8,
  parameter  int unsigned MANT_BITS = 23,
  localparam int unsigned WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  input  logic             round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SigW = MANT_BITS + 4;
  localparam int unsigned ExpW = EXP_BITS + 2;
  localparam int unsigned LzW  = $clog2(SigW);
  localparam logic [63:0]           QnanWide = fp_qnan(EXP_BITS, MANT_BITS);
  localparam logic [WIDTH-1:0]      Qnan     = QnanWide[WIDTH-1:0];
  localparam logic [EXP_BITS-1:0]   MaxShift = EXP_BITS'(SigW - 1);
  localparam logic signed [ExpW-1:0] ExpMax  = {2'b00, {EXP_BITS{1'b1}}};

  logic stall, advance;

  // Operand capture
  logic             v0_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_sel_q;
  round_mode_e      op_rm_q;

  // S1: classify, swap and align
  fp_class_e            cls_a, cls_b;
  logic                 sign_a, sign_b, a_ge_b;
  logic [EXP_BITS-1:0]  exp_x, exp_y, exp_diff, shamt;
  logic [MANT_BITS-1:0] mant_x, mant_y;
  logic [2*SigW-1:0]    y_wide;
  logic [SigW-1:0]      sig_x_d, sig_y_d;
  logic                 s1_special_d;
  logic [WIDTH-1:0]     s1_res_d;
  flags_t               s1_flags_d;

  logic                s1_valid_q, s1_special_q, s1_sign_q, s1_sub_q;
  logic [WIDTH-1:0]    s1_res_q;
  flags_t              s1_flags_q;
  logic [EXP_BITS-1:0] s1_exp_q;
  logic [SigW-1:0]     s1_sig_x_q, s1_sig_y_q;
  round_mode_e         s1_rm_q;

  // S2: significand add
  logic [SigW:0]          sum;
  logic [SigW-1:0]        s2_sig_d;
  logic signed [ExpW-1:0] s2_exp_d;

  logic                   s2_valid_q, s2_special_q, s2_sign_q;
  logic [WIDTH-1:0]       s2_res_q;
  flags_t                 s2_flags_q;
  logic signed [ExpW-1:0] s2_exp_q;
  logic [SigW-1:0]        s2_sig_q;
  round_mode_e            s2_rm_q;

  // S3: normalise and round
  logic [LzW-1:0]         lz;
  logic                   sig_zero, rnd_inc;
  logic [SigW-1:0]        norm;
  logic signed [ExpW-1:0] exp_n, exp_r;
  logic [MANT_BITS+1:0]   rounded;
  logic [MANT_BITS-1:0]   mant_f;
  logic [WIDTH-1:0]       res_d;
  flags_t                 flags_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  assign stall     = out_valid_q && !out_ready;
  assign advance   = !stall;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  assign cls_a  = fp_classify(64'(op_a_q), EXP_BITS, MANT_BITS);
  assign cls_b  = fp_classify(64'(op_b_q), EXP_BITS, MANT_BITS);
  assign sign_a = op_a_q[WIDTH-1];
  assign sign_b = op_b_q[WIDTH-1] ^ op_sel_q;
  // exp||mant orders magnitudes correctly for normal operands
  assign a_ge_b = op_a_q[WIDTH-2:0] >= op_b_q[WIDTH-2:0];

  assign exp_x    = a_ge_b ? op_a_q[WIDTH-2:MANT_BITS] : op_b_q[WIDTH-2:MANT_BITS];
  assign exp_y    = a_ge_b ? op_b_q[WIDTH-2:MANT_BITS] : op_a_q[WIDTH-2:MANT_BITS];
  assign mant_x   = a_ge_b ? op_a_q[MANT_BITS-1:0] : op_b_q[MANT_BITS-1:0];
  assign mant_y   = a_ge_b ? op_b_q[MANT_BITS-1:0] : op_a_q[MANT_BITS-1:0];
  assign exp_diff = exp_x - exp_y;
  assign shamt    = (exp_diff > MaxShift) ? MaxShift : exp_diff;
  assign y_wide   = {1'b1, mant_y, 3'b000, {SigW{1'b0}}} >> shamt;
  assign sig_x_d  = {1'b1, mant_x, 3'b000};
  assign sig_y_d  = {y_wide[2*SigW-1:SigW+1], y_wide[SigW] | (|y_wide[SigW-1:0])};

  always_comb begin
    s1_special_d = 1'b1;
    s1_res_d     = '0;
    s1_flags_d   = '0;
    if (cls_a inside {FpQnan, FpSnan} || cls_b inside {FpQnan, FpSnan}) begin
      s1_res_d           = Qnan;
      s1_flags_d.invalid = (cls_a == FpSnan) || (cls_b == FpSnan);
    end else if (cls_a == FpInf && cls_b == FpInf) begin
      if (sign_a != sign_b) begin
        s1_res_d           = Qnan;
        s1_flags_d.invalid = 1'b1;
      end else begin
        s1_res_d = op_a_q;
      end
    end else if (cls_a == FpInf) begin
      s1_res_d = op_a_q;
    end else if (cls_b == FpInf) begin
      s1_res_d = {sign_b, op_b_q[WIDTH-2:0]};
    end else if (cls_a == FpZero && cls_b == FpZero) begin
      s1_res_d = {sign_a & sign_b, {(WIDTH-1){1'b0}}};
    end else if (cls_b == FpZero) begin
      s1_res_d = op_a_q;
    end else if (cls_a == FpZero) begin
      s1_res_d = {sign_b, op_b_q[WIDTH-2:0]};
    end else begin
      s1_special_d = 1'b0;
    end
  end

  // Carry-out keeps the dropped LSB alive in the sticky position
  always_comb begin
    sum      = s1_sub_q ? ({1'b0, s1_sig_x_q} - {1'b0, s1_sig_y_q})
                        : ({1'b0, s1_sig_x_q} + {1'b0, s1_sig_y_q});
    s2_exp_d = {2'b00, s1_exp_q};
    s2_sig_d = sum[SigW-1:0];
    if (sum[SigW]) begin
      s2_sig_d = {sum[SigW:2], sum[1] | sum[0]};
      s2_exp_d = s2_exp_d + ExpW'(1);
    end
  end

  fp_lzc #(
    .Width(SigW)
  ) u_lzc (
    .vec_i  (s2_sig_q),
    .count_o(lz),
    .zero_o (sig_zero)
  );

  always_comb begin
    norm    = s2_sig_q << lz;
    exp_n   = s2_exp_q - ExpW'(lz);
    rnd_inc = (s2_rm_q == RoundRne) && norm[2] && (norm[1] || norm[0] || norm[3]);
    rounded = {1'b0, norm[SigW-1:3]} + (MANT_BITS+2)'(rnd_inc);
    exp_r   = exp_n + ExpW'(rounded[MANT_BITS+1]);
    mant_f  = rounded[MANT_BITS+1] ? rounded[MANT_BITS:1] : rounded[MANT_BITS-1:0];
    res_d   = '0;
    flags_d = '0;
    if (s2_special_q) begin
      res_d   = s2_res_q;
      flags_d = s2_flags_q;
    end else if (sig_zero) begin
      res_d = '0;
    end else if (exp_n[ExpW-1] || exp_n == '0) begin
      res_d             = {s2_sign_q, {(WIDTH-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else if (exp_r >= ExpMax) begin
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
      if (s2_rm_q == RoundRtz) begin
        res_d = {s2_sign_q, {(EXP_BITS-1){1'b1}}, 1'b0, {MANT_BITS{1'b1}}};
      end else begin
        res_d = {s2_sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      end
    end else begin
      res_d           = {s2_sign_q, exp_r[EXP_BITS-1:0], mant_f};
      flags_d.inexact = norm[2] || norm[1] || norm[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 1'b0;
      op_rm_q      <= RoundRne;
      s1_valid_q   <= 1'b0;
      s1_special_q <= 1'b0;
      s1_res_q     <= '0;
      s1_flags_q   <= '0;
      s1_sign_q    <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_exp_q     <= '0;
      s1_sig_x_q   <= '0;
      s1_sig_y_q   <= '0;
      s1_rm_q      <= RoundRne;
      s2_valid_q   <= 1'b0;
      s2_special_q <= 1'b0;
      s2_res_q     <= '0;
      s2_flags_q   <= '0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_sig_q     <= '0;
      s2_rm_q      <= RoundRne;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
    end else if (advance) begin
      v0_q        <= in_valid;
      s1_valid_q  <= v0_q;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (in_valid) begin
        op_a_q   <= a;
        op_b_q   <= b;
        op_sel_q <= operation_select;
        op_rm_q  <= round_mode_e'(round_mode);
      end
      if (v0_q) begin
        s1_special_q <= s1_special_d;
        s1_res_q     <= s1_res_d;
        s1_flags_q   <= s1_flags_d;
        s1_sign_q    <= a_ge_b ? sign_a : sign_b;
        s1_sub_q     <= sign_a ^ sign_b;
        s1_exp_q     <= exp_x;
        s1_sig_x_q   <= sig_x_d;
        s1_sig_y_q   <= sig_y_d;
        s1_rm_q      <= op_rm_q;
      end
      if (s1_valid_q) begin
        s2_special_q <= s1_special_q;
        s2_res_q     <= s1_res_q;
        s2_flags_q   <= s1_flags_q;
        s2_sign_q    <= s1_sign_q;
        s2_exp_q     <= s2_exp_d;
        s2_sig_q     <= s2_sig_d;
        s2_rm_q      <= s1_rm_q;
      end
      if (s2_valid_q) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

endmodule

// File: doc/fp_add_sub_pipe.md
Name: fp_add_sub_pipe

Overview:
- Parametrised, pipelined IEEE-754 adder/subtractor; next generation of the single-cycle `add_sub_main` core.
- Generalised exponent and mantissa widths.
- Adds a valid/ready handshake with backpressure, two rounding modes, full special-value handling and sticky-free per-result exception flags.
- Sits between the operand-issue logic and the result writeback of the FP datapath.

Parameters:
- EXP_BITS, 8, exponent field width.
- MANT_BITS, 23, stored mantissa width (no hidden bit).
- WIDTH, 1+EXP_BITS+MANT_BITS, total operand and result width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- operation_select  in  1  0 = A+B, 1 = A−B.
- round_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  rounded result.
- flags  out  4  {invalid, overflow, underflow, inexact} for this result.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage-valid bits clear, so out_valid=0.
  - result=0 and flags=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Handshake and pipeline:
  - Transfer occurs when valid&&ready on each side.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - All three stages advance together when !stall; bubbles are not compressed.
  - Latency: a transfer accepted at edge N gives out_valid at edge N+3 with no stall.
  - Throughput is 1 per cycle.
  - While stalled, result and flags hold stable.
  - Operands and mode are captured only on a transfer.
- S1 (unpack/align):
  - Effective B sign = b.sign XOR operation_select.
  - Classify each operand as zero, inf, NaN or normal.
  - Subnormal inputs are flushed to zero (FTZ).
  - Swap so that |X| ≥ |Y|.
  - Right-shift Y's significand by the exponent difference, keeping guard, round and sticky bits.
  - Shift amount saturates at MANT_BITS+3; all shifted-out bits OR into sticky.
- S2 (add):
  - Add or subtract the (MANT_BITS+4)-bit significands according to the effective operation.
  - Carry-out increments the exponent and shifts right one place, with sticky preserved.
- S3 (normalize/round):
  - Leading-zero count, then left shift and exponent decrement.
  - RNE: increment when G && (R||S||LSB).
  - RTZ: truncate.
  - Rounding carry renormalises.
  - inexact = G||R||S, evaluated before rounding.
- Special cases (override the arithmetic path, resolved in S1 and carried down):
  - Any NaN input gives canonical qNaN {0, all-ones, 1, 0…}; invalid=1 only for a signalling NaN input.
  - inf − inf (effective) gives qNaN with invalid=1.
  - inf ± finite gives that inf, no flags.
  - Exact zero difference gives +0.
  - (−0)+(−0) gives −0.
  - x ± 0 gives x.
- Overflow:
  - Biased exponent ≥ all-ones sets overflow=1 and inexact=1.
  - RNE gives ±inf.
  - RTZ gives ±max-finite.
- Underflow:
  - Normalised exponent ≤ 0 gives ±0 (FTZ output).
  - Sets underflow=1, and inexact=1 when the result is nonzero before flush.
- Flags are per-result and valid only with out_valid.

Decomposition:
- Package fp_pkg holds:
  - fp_class_e (ZERO, NORM, INF, QNAN, SNAN).
  - round_mode_e.
  - Parametrised field-extraction functions.
  - The flags_t struct.
  - The canonical qNaN constant function.
- One sub-module, fp_lzc, is a parametrised leading-zero counter used by S3.

Test Plan:
- 3.0+4.0 (0x40400000, 0x40800000, op=0, RNE) → 0x40E00000, flags=0, out_valid exactly 3 cycles after the transfer.
- 5.0−2.0 (0x40A00000, 0x40000000, op=1) → 0x40400000. Then −4.0+4.0 (0xC0800000, 0x40800000) → 0x00000000.
- (−5.0)−(−2.0) (0xC0A00000, 0xC0000000, op=1) → 0xC0400000. Then 1.0+2^-24 (0x3F800000, 0x33800000):
  - RNE → 0x3F800000 with inexact=1 (tie to even).
  - RTZ gives the same value.
- +inf−(+inf) (0x7F800000, 0x7F800000, op=1) → 0x7FC00000, invalid=1.
- 0x7F7FFFFF+0x7F7FFFFF:
  - RNE → 0x7F800000, overflow=1, inexact=1.
  - RTZ → 0x7F7FFFFF with the same flags.
- Backpressure:
  - Issue 5 back-to-back ops with out_ready low for 4 cycles: in_ready drops, and result holds stable.
  - After release, all 5 results emerge in order with no loss or duplication.
  - Assert reset for 1 cycle mid-stream: out_valid=0 immediately and no stale results afterwards.
